// File: rtl/data_mem_bridge_pkg.sv
// Shared types for the data memory bridge: access-size encodings (RISC-V funct3)
// and the bridge FSM state.
package data_mem_bridge_pkg;

    typedef logic [2:0] mem_size_t;

    localparam mem_size_t MEM_BYTE   = 3'b000;
    localparam mem_size_t MEM_HALF   = 3'b001;
    localparam mem_size_t MEM_WORD   = 3'b010;
    localparam mem_size_t MEM_BYTE_U = 3'b100;
    localparam mem_size_t MEM_HALF_U = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } bridge_state_t;

endpackage

// File: rtl/data_mem_bridge_lane_align.sv
// Combinational lane steering: byte enables, replicated store data and the
// alignment check for a request, plus right-alignment of returned read data.
module mem_lane_align
    import data_mem_bridge_pkg::*;
(
    input  mem_size_t   mode,
    input  logic [1:0]  off,
    input  logic [31:0] wdata_in,
    output logic [3:0]  be,
    output logic [31:0] wdata_out,
    output logic        misaligned,
    input  logic [1:0]  rd_off,
    input  logic [31:0] rdata_in,
    output logic [31:0] rdata_out
);

    logic is_byte;
    logic is_half;

    // Signed and unsigned loads share lanes; any other encoding is a word.
    assign is_byte = (mode == MEM_BYTE) || (mode == MEM_BYTE_U);
    assign is_half = (mode == MEM_HALF) || (mode == MEM_HALF_U);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign be[gi] = is_byte ? (off == LANE)
                          : is_half ? (off[1] == LANE[1])
                          : 1'b1;
        end
    endgenerate

    always_comb begin
        wdata_out = wdata_in;
        if (is_byte) begin
            wdata_out = {4{wdata_in[7:0]}};
        end else if (is_half) begin
            wdata_out = {2{wdata_in[15:0]}};
        end
    end

    assign misaligned = is_half ? off[0] : (!is_byte && (off != 2'b00));

    assign rdata_out = rdata_in >> {rd_off, 3'b000};

endmodule

// File: rtl/data_mem_bridge.sv
// Converts the core's byte/half/word RAM request into a word-aligned bus
// transaction with byte enables, stalling the core until the bus acknowledges.
module data_mem_bridge
    import data_mem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] FAULT_DATA     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] ram_address,
    input  logic        ram_enable,
    input  logic [31:0] ram_write_data,
    input  logic        ram_write_enable,
    input  logic [2:0]  ram_write_mode,
    input  logic        ram_read_enable,
    input  logic [2:0]  ram_read_mode,
    output logic [31:0] ram_read_data,
    output logic        ram_wait,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        misaligned,
    output logic        bus_fault
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    bridge_state_t    state_q, state_d;
    logic             bus_req_q, bus_req_d;
    logic             bus_we_q, bus_we_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [3:0]       bus_be_q, bus_be_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic [1:0]       rd_off_q, rd_off_d;
    logic [31:0]      held_q, held_d;
    logic             misaligned_q, misaligned_d;
    logic             bus_fault_q, bus_fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    mem_size_t   req_mode;
    logic        req_valid;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        req_misaligned;
    logic [31:0] rd_aligned;
    logic        completing;
    logic        can_accept;
    logic        timeout_hit;

    // A simultaneous read and write request is treated as the write.
    assign req_mode  = ram_write_enable ? ram_write_mode : ram_read_mode;
    assign req_valid = ram_enable && (ram_read_enable || ram_write_enable);

    mem_lane_align u_lane_align (
        .mode       (req_mode),
        .off        (ram_address[1:0]),
        .wdata_in   (ram_write_data),
        .be         (req_be),
        .wdata_out  (req_wdata),
        .misaligned (req_misaligned),
        .rd_off     (rd_off_q),
        .rdata_in   (bus_rdata),
        .rdata_out  (rd_aligned)
    );

    assign completing  = (state_q == BUSY) && bus_ack;
    assign can_accept  = (state_q == IDLE) || completing;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TMO_LAST);

    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        rd_off_d     = rd_off_q;
        held_d       = held_q;
        misaligned_d = 1'b0;
        bus_fault_d  = 1'b0;
        cnt_d        = cnt_q;

        if (state_q == BUSY) begin
            if (bus_ack) begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
                cnt_d     = '0;
                if (!bus_we_q) begin
                    held_d = rd_aligned;
                end
            end else if (timeout_hit) begin
                state_d     = IDLE;
                bus_req_d   = 1'b0;
                bus_fault_d = 1'b1;
                held_d      = FAULT_DATA;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // The completing cycle has ram_wait low, so the core may already
        // present its next access; take it on the same edge.
        if (can_accept && req_valid) begin
            if (req_misaligned) begin
                misaligned_d = 1'b1;
                held_d       = FAULT_DATA;
            end else begin
                state_d     = BUSY;
                bus_req_d   = 1'b1;
                bus_we_d    = ram_write_enable;
                bus_addr_d  = {ram_address[31:2], 2'b00};
                bus_be_d    = req_be;
                bus_wdata_d = req_wdata;
                rd_off_d    = ram_address[1:0];
                cnt_d       = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= '0;
            bus_wdata_q  <= '0;
            rd_off_q     <= '0;
            held_q       <= '0;
            misaligned_q <= 1'b0;
            bus_fault_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
            rd_off_q     <= rd_off_d;
            held_q       <= held_d;
            misaligned_q <= misaligned_d;
            bus_fault_q  <= bus_fault_d;
            cnt_q        <= cnt_d;
        end
    end

    // Read data bypasses the holding register in the ack cycle so a
    // zero-wait load completes without a stall.
    assign ram_read_data = (completing && !bus_we_q) ? rd_aligned : held_q;
    assign ram_wait      = (state_q == BUSY) && !bus_ack;
    assign bus_req       = bus_req_q;
    assign bus_we        = bus_we_q;
    assign bus_addr      = bus_addr_q;
    assign bus_be        = bus_be_q;
    assign bus_wdata     = bus_wdata_q;
    assign misaligned    = misaligned_q;
    assign bus_fault     = bus_fault_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed self-checking bench for data_mem_bridge: stores, loads, stalls,
// misalignment, timeout, back-to-back issue and reset during a transaction.
module tb_data_mem_bridge;

    localparam logic [31:0] FAULT = 32'hFA01_7BAD;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] ram_address = '0;
    logic        ram_enable = 1'b0;
    logic [31:0] ram_write_data = '0;
    logic        ram_write_enable = 1'b0;
    logic [2:0]  ram_write_mode = '0;
    logic        ram_read_enable = 1'b0;
    logic [2:0]  ram_read_mode = '0;
    logic [31:0] ram_read_data;
    logic        ram_wait;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        misaligned;
    logic        bus_fault;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    data_mem_bridge #(
        .TIMEOUT_CYCLES (4),
        .FAULT_DATA     (FAULT)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .ram_address      (ram_address),
        .ram_enable       (ram_enable),
        .ram_write_data   (ram_write_data),
        .ram_write_enable (ram_write_enable),
        .ram_write_mode   (ram_write_mode),
        .ram_read_enable  (ram_read_enable),
        .ram_read_mode    (ram_read_mode),
        .ram_read_data    (ram_read_data),
        .ram_wait         (ram_wait),
        .bus_req          (bus_req),
        .bus_we           (bus_we),
        .bus_addr         (bus_addr),
        .bus_be           (bus_be),
        .bus_wdata        (bus_wdata),
        .bus_ack          (bus_ack),
        .bus_rdata        (bus_rdata),
        .misaligned       (misaligned),
        .bus_fault        (bus_fault)
    );

    task automatic clear_req();
        ram_enable       = 1'b0;
        ram_write_enable = 1'b0;
        ram_read_enable  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        tests++; if (bus_req !== 1'b0) begin failed++; $display("FAIL rst_req: got %0b want 0", bus_req); end
        tests++; if (ram_wait !== 1'b0) begin failed++; $display("FAIL rst_wait: got %0b want 0", ram_wait); end
        tests++; if (ram_read_data !== 32'h0) begin failed++; $display("FAIL rst_rdata: got %h want 0", ram_read_data); end
        tests++; if ({bus_addr, bus_be, bus_wdata} !== '0) begin failed++; $display("FAIL rst_bus: got %h %b %h want 0", bus_addr, bus_be, bus_wdata); end
        tests++; if ({misaligned, bus_fault, bus_we} !== 3'b000) begin failed++; $display("FAIL rst_pulses: got %b want 000", {misaligned, bus_fault, bus_we}); end
        @(negedge clk);
        reset_n = 1'b1;
        $display("[TB] reset checked");
    endtask

    task automatic test_store_byte();
        @(negedge clk);
        ram_enable = 1'b1; ram_write_enable = 1'b1; ram_write_mode = 3'b000;
        ram_address = 32'h0000_1003; ram_write_data = 32'h0000_00A5;
        @(negedge clk);
        clear_req(); bus_ack = 1'b1;
        #1;
        tests++; if (bus_req !== 1'b1) begin failed++; $display("FAIL sb_req: got %0b want 1", bus_req); end
        tests++; if (bus_we !== 1'b1) begin failed++; $display("FAIL sb_we: got %0b want 1", bus_we); end
        tests++; if (bus_addr !== 32'h0000_1000) begin failed++; $display("FAIL sb_addr: got %h want 00001000", bus_addr); end
        tests++; if (bus_be !== 4'b1000) begin failed++; $display("FAIL sb_be: got %b want 1000", bus_be); end
        tests++; if (bus_wdata !== 32'hA5A5_A5A5) begin failed++; $display("FAIL sb_wdata: got %h want a5a5a5a5", bus_wdata); end
        tests++; if (ram_wait !== 1'b0) begin failed++; $display("FAIL sb_wait: got %0b want 0", ram_wait); end
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        tests++; if (bus_req !== 1'b0) begin failed++; $display("FAIL sb_req_drop: got %0b want 0", bus_req); end
        tests++; if (ram_read_data !== 32'h0) begin failed++; $display("FAIL sb_held: got %h want 0", ram_read_data); end
        $display("[TB] store byte 0xa5 -> 0x1003");
    endtask

    task automatic test_load_half();
        @(negedge clk);
        ram_enable = 1'b1; ram_read_enable = 1'b1; ram_read_mode = 3'b001;
        ram_address = 32'h0000_2002;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            clear_req();
            #1;
            tests++; if (ram_wait !== 1'b1) begin failed++; $display("FAIL lh_wait%0d: got %0b want 1", i, ram_wait); end
            tests++; if ({bus_req, bus_we, bus_be} !== 6'b10_1100) begin failed++; $display("FAIL lh_bus%0d: got %b want 101100", i, {bus_req, bus_we, bus_be}); end
        end
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hBEEF_1234;
        #1;
        tests++; if (ram_wait !== 1'b0) begin failed++; $display("FAIL lh_ack_wait: got %0b want 0", ram_wait); end
        tests++; if (ram_read_data !== 32'h0000_BEEF) begin failed++; $display("FAIL lh_data: got %h want 0000beef", ram_read_data); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus_ack = 1'b0; bus_rdata = 32'h5555_0000 + 32'(i);
            #1;
            tests++; if (ram_read_data !== 32'h0000_BEEF) begin failed++; $display("FAIL lh_hold%0d: got %h want 0000beef", i, ram_read_data); end
            tests++; if (bus_req !== 1'b0) begin failed++; $display("FAIL lh_idle%0d: got %0b want 0", i, bus_req); end
        end
        $display("[TB] load half 0x2002 -> 0000beef");
    endtask

    task automatic test_timeout();
        @(negedge clk);
        ram_enable = 1'b1; ram_read_enable = 1'b1; ram_read_mode = 3'b000;
        ram_address = 32'h0000_4000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clear_req();
            #1;
            tests++; if ({ram_wait, bus_req, bus_fault} !== 3'b110) begin failed++; $display("FAIL to_busy%0d: got %b want 110", i, {ram_wait, bus_req, bus_fault}); end
        end
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        #1;
        tests++; if (bus_fault !== 1'b1) begin failed++; $display("FAIL to_fault: got %0b want 1", bus_fault); end
        tests++; if ({bus_req, ram_wait} !== 2'b00) begin failed++; $display("FAIL to_drop: got %b want 00", {bus_req, ram_wait}); end
        tests++; if (ram_read_data !== FAULT) begin failed++; $display("FAIL to_data: got %h want %h", ram_read_data, FAULT); end
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        tests++; if ({bus_fault, bus_req, ram_wait} !== 3'b000) begin failed++; $display("FAIL to_late_ack: got %b want 000", {bus_fault, bus_req, ram_wait}); end
        tests++; if (ram_read_data !== FAULT) begin failed++; $display("FAIL to_late_data: got %h want %h", ram_read_data, FAULT); end
        $display("[TB] load byte 0x4000 timed out");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        ram_enable = 1'b1; ram_write_enable = 1'b1; ram_write_mode = 3'b010;
        ram_address = 32'h0000_0010; ram_write_data = 32'h1122_3344;
        @(negedge clk);
        bus_ack = 1'b1;
        ram_write_enable = 1'b0; ram_read_enable = 1'b1; ram_read_mode = 3'b000;
        ram_address = 32'h0000_0015;
        #1;
        tests++; if ({bus_req, bus_we, bus_be} !== 6'b11_1111) begin failed++; $display("FAIL bb_wr: got %b want 111111", {bus_req, bus_we, bus_be}); end
        tests++; if (bus_wdata !== 32'h1122_3344) begin failed++; $display("FAIL bb_wdata: got %h want 11223344", bus_wdata); end
        tests++; if (ram_wait !== 1'b0) begin failed++; $display("FAIL bb_wait: got %0b want 0", ram_wait); end
        @(negedge clk);
        clear_req(); bus_rdata = 32'hAABB_CCDD;
        #1;
        tests++; if ({bus_req, bus_we, bus_be} !== 6'b10_0010) begin failed++; $display("FAIL bb_rd: got %b want 100010", {bus_req, bus_we, bus_be}); end
        tests++; if (bus_addr !== 32'h0000_0014) begin failed++; $display("FAIL bb_addr: got %h want 00000014", bus_addr); end
        tests++; if (ram_read_data !== 32'h00AA_BBCC) begin failed++; $display("FAIL bb_data: got %h want 00aabbcc", ram_read_data); end
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        tests++; if ({bus_req, ram_wait} !== 2'b00) begin failed++; $display("FAIL bb_idle: got %b want 00", {bus_req, ram_wait}); end
        tests++; if (ram_read_data !== 32'h00AA_BBCC) begin failed++; $display("FAIL bb_held: got %h want 00aabbcc", ram_read_data); end
        $display("[TB] store word 0x10 then load byte 0x15");
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        ram_enable = 1'b0; ram_read_enable = 1'b1; ram_read_mode = 3'b010;
        ram_address = 32'h0000_3001;
        @(negedge clk);
        #1;
        tests++; if ({misaligned, bus_req} !== 2'b00) begin failed++; $display("FAIL ma_disabled: got %b want 00", {misaligned, bus_req}); end
        tests++; if (ram_read_data !== 32'h00AA_BBCC) begin failed++; $display("FAIL ma_disabled_data: got %h want 00aabbcc", ram_read_data); end
        ram_enable = 1'b1;
        @(negedge clk);
        clear_req();
        #1;
        tests++; if (misaligned !== 1'b1) begin failed++; $display("FAIL ma_pulse: got %0b want 1", misaligned); end
        tests++; if (bus_req !== 1'b0) begin failed++; $display("FAIL ma_req: got %0b want 0", bus_req); end
        tests++; if (ram_read_data !== FAULT) begin failed++; $display("FAIL ma_data: got %h want %h", ram_read_data, FAULT); end
        ram_enable = 1'b1; ram_write_enable = 1'b1; ram_write_mode = 3'b001;
        ram_address = 32'h0000_3005;
        #1;
        tests++; if (ram_wait !== 1'b0) begin failed++; $display("FAIL ma_wait: got %0b want 0", ram_wait); end
        @(negedge clk);
        clear_req();
        #1;
        tests++; if ({misaligned, bus_req} !== 2'b10) begin failed++; $display("FAIL ma_half: got %b want 10", {misaligned, bus_req}); end
        @(negedge clk);
        #1;
        tests++; if ({misaligned, bus_req} !== 2'b00) begin failed++; $display("FAIL ma_once: got %b want 00", {misaligned, bus_req}); end
        $display("[TB] misaligned word 0x3001 and half 0x3005 rejected");
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        ram_enable = 1'b1; ram_read_enable = 1'b1; ram_read_mode = 3'b010;
        ram_address = 32'h0000_5000;
        @(negedge clk);
        clear_req();
        #1;
        tests++; if ({bus_req, ram_wait} !== 2'b11) begin failed++; $display("FAIL rb_busy: got %b want 11", {bus_req, ram_wait}); end
        tests++; if (bus_addr !== 32'h0000_5000) begin failed++; $display("FAIL rb_addr: got %h want 00005000", bus_addr); end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        tests++; if ({bus_req, ram_wait} !== 2'b00) begin failed++; $display("FAIL rb_drop: got %b want 00", {bus_req, ram_wait}); end
        tests++; if (ram_read_data !== 32'h0) begin failed++; $display("FAIL rb_data: got %h want 0", ram_read_data); end
        @(negedge clk);
        #1;
        tests++; if (bus_req !== 1'b0) begin failed++; $display("FAIL rb_idle: got %0b want 0", bus_req); end
        $display("[TB] reset during load word 0x5000");
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_half();
        test_timeout();
        test_back_to_back();
        test_misaligned();
        test_reset_busy();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
